// File: rtl/store_queue_pkg.sv
// Store queue shared types: entry record, lookup request/response
// packets and the queue geometry constants.
package store_queue_pkg;

    localparam int LSQ  = 3;
    localparam int XLEN = 32;

    typedef struct packed {
        logic            valid;
        logic            executed;
        logic [XLEN-1:2] addr;
        logic [3:0]      usebytes;
        logic [XLEN-1:0] data;
    } SQ_ENTRY;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [LSQ-1:0]  tail_pos;
    } LOAD_SQ_PACKET;

    typedef struct packed {
        logic            stall;
        logic [3:0]      usebytes;
        logic [XLEN-1:0] data;
    } SQ_LOAD_PACKET;

    function automatic logic [LSQ-1:0] sq_inc(
        input logic [LSQ-1:0] i
    );
        return i + 1'b1;
    endfunction

endpackage

// File: rtl/store_queue_if.sv
// Bundle of every store queue signal except clock and reset.
// The queue is the slave; dispatch, store FU, ROB, load FU are master.
interface store_queue_if;
    import store_queue_pkg::*;

    logic            dispatch_en;
    logic            sq_full;
    logic [LSQ-1:0]  sq_tail;
    logic            exe_valid;
    logic [LSQ-1:0]  exe_idx;
    logic [XLEN-1:0] exe_addr;
    logic [3:0]      exe_usebytes;
    logic [XLEN-1:0] exe_data;
    logic            retire_en;
    logic            squash;
    LOAD_SQ_PACKET   sq_lookup;
    SQ_LOAD_PACKET   sq_result;
    logic            mem_wr_en;
    logic [XLEN-1:0] mem_addr;
    logic [3:0]      mem_usebytes;
    logic [XLEN-1:0] mem_data;

    modport slave (
        input  dispatch_en,
        output sq_full,
        output sq_tail,
        input  exe_valid,
        input  exe_idx,
        input  exe_addr,
        input  exe_usebytes,
        input  exe_data,
        input  retire_en,
        input  squash,
        input  sq_lookup,
        output sq_result,
        output mem_wr_en,
        output mem_addr,
        output mem_usebytes,
        output mem_data
    );

    modport master (
        output dispatch_en,
        input  sq_full,
        input  sq_tail,
        output exe_valid,
        output exe_idx,
        output exe_addr,
        output exe_usebytes,
        output exe_data,
        output retire_en,
        output squash,
        output sq_lookup,
        input  sq_result,
        input  mem_wr_en,
        input  mem_addr,
        input  mem_usebytes,
        input  mem_data
    );

endinterface

// File: rtl/sq_forward_lookup.sv
// Age-ordered scan from head to the load's tail_pos; any unexecuted
// store stalls the load, otherwise the youngest match wins per byte.
module sq_forward_lookup
    import store_queue_pkg::*;
#(
    parameter int SQ_DEPTH = 2**LSQ
) (
    input  SQ_ENTRY       entries [SQ_DEPTH],
    input  logic [LSQ-1:0] head,
    input  LOAD_SQ_PACKET lookup,
    output SQ_LOAD_PACKET result
);

    logic [LSQ-1:0]  span;
    logic [LSQ-1:0]  idx;
    logic            stall;
    logic [3:0]      fwd_bytes;
    logic [XLEN-1:0] fwd_data;
    logic            unused_addr_lsb;

    assign unused_addr_lsb = ^lookup.addr[1:0];

    // Walk oldest to youngest so later matches overwrite older ones.
    always_comb begin
        span      = lookup.tail_pos - head;
        idx       = head;
        stall     = 1'b0;
        fwd_bytes = 4'b0;
        fwd_data  = '0;
        for (int i = 0; i < SQ_DEPTH; i++) begin
            idx = head + LSQ'(i);
            if (LSQ'(i) < span) begin
                if (!entries[idx].executed) begin
                    stall = 1'b1;
                end else if (entries[idx].addr
                             == lookup.addr[XLEN-1:2]) begin
                    for (int b = 0; b < 4; b++) begin
                        if (entries[idx].usebytes[b]) begin
                            fwd_bytes[b]       = 1'b1;
                            fwd_data[8*b +: 8] =
                                entries[idx].data[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    // A stalled load gets no partial data.
    always_comb begin
        result = '0;
        if (stall) begin
            result.stall = 1'b1;
        end else begin
            result.usebytes = fwd_bytes;
            result.data     = fwd_data;
        end
    end

endmodule

// File: rtl/store_queue.sv
// Circular store queue: allocates at dispatch, fills at execute,
// forwards to loads, and writes the head store to the cache at retire.
module store_queue
    import store_queue_pkg::*;
#(
    parameter int SQ_DEPTH = 2**LSQ
) (
    input  logic          clock,
    input  logic          reset,
    store_queue_if.slave  sq
);

    SQ_ENTRY        entries [SQ_DEPTH];
    logic [LSQ-1:0] head;
    logic [LSQ-1:0] tail;
    logic [LSQ-1:0] count;
    logic [LSQ-1:0] head_nxt;
    logic           disp_ok;
    logic           unused_exe_lsb;

    assign unused_exe_lsb = ^sq.exe_addr[1:0];

    // One slot stays free so tail_pos == head always means empty.
    assign sq.sq_full = (count == LSQ'(SQ_DEPTH - 1));
    assign sq.sq_tail = tail;
    assign disp_ok    = sq.dispatch_en && !sq.sq_full;
    assign head_nxt   = sq.retire_en ? sq_inc(head) : head;

    // Queue pointers, entry array and the registered cache write port.
    always_ff @(posedge clock) begin
        if (!reset) begin
            head            <= '0;
            tail            <= '0;
            count           <= '0;
            sq.mem_wr_en    <= 1'b0;
            sq.mem_addr     <= '0;
            sq.mem_usebytes <= 4'b0;
            sq.mem_data     <= '0;
            for (int i = 0; i < SQ_DEPTH; i++) begin
                entries[i] <= '0;
            end
        end else begin
            sq.mem_wr_en <= sq.retire_en;
            if (sq.retire_en) begin
                sq.mem_addr     <= {entries[head].addr, 2'b00};
                sq.mem_usebytes <= entries[head].usebytes;
                sq.mem_data     <= entries[head].data;
                entries[head].valid <= 1'b0;
            end
            if (sq.exe_valid) begin
                entries[sq.exe_idx].executed <= 1'b1;
                entries[sq.exe_idx].addr     <=
                    sq.exe_addr[XLEN-1:2];
                entries[sq.exe_idx].usebytes <= sq.exe_usebytes;
                entries[sq.exe_idx].data     <= sq.exe_data;
            end
            if (sq.squash) begin
                for (int i = 0; i < SQ_DEPTH; i++) begin
                    entries[i].valid <= 1'b0;
                end
                tail  <= head_nxt;
                count <= '0;
            end else begin
                if (disp_ok) begin
                    entries[tail].valid    <= 1'b1;
                    entries[tail].executed <= 1'b0;
                    tail <= sq_inc(tail);
                end
                count <= count + LSQ'(disp_ok)
                       - LSQ'(sq.retire_en);
            end
            head <= head_nxt;
        end
    end

    sq_forward_lookup #(
        .SQ_DEPTH (SQ_DEPTH)
    ) u_lookup (
        .entries (entries),
        .head    (head),
        .lookup  (sq.sq_lookup),
        .result  (sq.sq_result)
    );

endmodule

// File: tb/tb_store_queue.sv
// Directed bench for store_queue: reset, forwarding, stall, wrap,
// retire and squash sequences with hand-computed expectations.
module tb_store_queue;
    import store_queue_pkg::*;

    logic clock;
    logic reset;
    int   errors;
    int   checks;

    store_queue_if bus ();

    store_queue dut (
        .clock (clock),
        .reset (reset),
        .sq    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        bus.dispatch_en  = 1'b0;
        bus.exe_valid    = 1'b0;
        bus.exe_idx      = '0;
        bus.exe_addr     = '0;
        bus.exe_usebytes = 4'b0;
        bus.exe_data     = '0;
        bus.retire_en    = 1'b0;
        bus.squash       = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic dispatch(input int n);
        for (int i = 0; i < n; i++) begin
            bus.dispatch_en = 1'b1;
            tick();
        end
        bus.dispatch_en = 1'b0;
    endtask

    task automatic exec(input logic [LSQ-1:0] idx,
                        input logic [31:0] a,
                        input logic [3:0] m,
                        input logic [31:0] d);
        bus.exe_valid    = 1'b1;
        bus.exe_idx      = idx;
        bus.exe_addr     = a;
        bus.exe_usebytes = m;
        bus.exe_data     = d;
        tick();
        bus.exe_valid    = 1'b0;
    endtask

    task automatic look(input logic [31:0] a,
                        input logic [LSQ-1:0] tp);
        bus.sq_lookup.addr     = a;
        bus.sq_lookup.tail_pos = tp;
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        bus.sq_lookup = '0;

        // reset
        do_reset();
        look(32'h0, 3'd0);
        chk("rst_tail", 64'(bus.sq_tail), 64'd0);
        chk("rst_full", 64'(bus.sq_full), 64'd0);
        chk("rst_wr", 64'(bus.mem_wr_en), 64'd0);
        chk("rst_res", 64'(bus.sq_result), 64'd0);

        // youngest-wins forwarding
        dispatch(2);
        chk("fw_tail", 64'(bus.sq_tail), 64'd2);
        exec(3'd0, 32'h100, 4'b1111, 32'hAABBCCDD);
        exec(3'd1, 32'h101, 4'b0001, 32'h00000011);
        look(32'h100, 3'd2);
        chk("fw_young", 64'(bus.sq_result),
            64'({1'b0, 4'hF, 32'hAABBCC11}));
        look(32'h100, 3'd1);
        chk("fw_old", 64'(bus.sq_result),
            64'({1'b0, 4'hF, 32'hAABBCCDD}));
        look(32'h104, 3'd2);
        chk("fw_miss", 64'(bus.sq_result), 64'd0);

        // stall
        do_reset();
        dispatch(2);
        exec(3'd1, 32'h100, 4'b0011, 32'h00005566);
        look(32'h100, 3'd2);
        chk("st_on", 64'(bus.sq_result),
            64'({1'b1, 4'h0, 32'h0}));
        bus.exe_valid    = 1'b1;
        bus.exe_idx      = 3'd0;
        bus.exe_addr     = 32'h100;
        bus.exe_usebytes = 4'b1100;
        bus.exe_data     = 32'h77880000;
        #1;
        chk("st_same_cyc", 64'(bus.sq_result.stall), 64'd1);
        tick();
        bus.exe_valid = 1'b0;
        look(32'h100, 3'd2);
        chk("st_off", 64'(bus.sq_result),
            64'({1'b0, 4'hF, 32'h77885566}));
        look(32'h100, 3'd0);
        chk("st_empty", 64'(bus.sq_result), 64'd0);

        // full and wrap
        do_reset();
        dispatch(7);
        chk("fl_full", 64'(bus.sq_full), 64'd1);
        chk("fl_tail7", 64'(bus.sq_tail), 64'd7);
        dispatch(1);
        chk("fl_ignored", 64'(bus.sq_tail), 64'd7);
        exec(3'd0, 32'h400, 4'b1111, 32'h0BADF00D);
        exec(3'd1, 32'h300, 4'b1111, 32'h11111111);
        for (int i = 2; i < 7; i++) begin
            exec(LSQ'(i), 32'h500, 4'b1111, 32'h0);
        end
        bus.retire_en = 1'b1;
        #1;
        chk("fl_still", 64'(bus.sq_full), 64'd1);
        tick();
        bus.retire_en = 1'b0;
        chk("fl_free", 64'(bus.sq_full), 64'd0);
        chk("fl_wr_addr", 64'(bus.mem_addr), 64'h400);
        dispatch(1);
        chk("fl_wrap", 64'(bus.sq_tail), 64'd0);
        chk("fl_refull", 64'(bus.sq_full), 64'd1);
        exec(3'd7, 32'h300, 4'b0010, 32'h0000EE00);
        look(32'h300, 3'd0);
        chk("fl_wrap_fw", 64'(bus.sq_result),
            64'({1'b0, 4'hF, 32'h1111EE11}));

        // retire
        do_reset();
        dispatch(1);
        exec(3'd0, 32'h200, 4'b1100, 32'h12340000);
        bus.retire_en = 1'b1;
        look(32'h200, 3'd1);
        chk("rt_visible", 64'(bus.sq_result),
            64'({1'b0, 4'hC, 32'h12340000}));
        chk("rt_wr_lat", 64'(bus.mem_wr_en), 64'd0);
        tick();
        bus.retire_en = 1'b0;
        chk("rt_wr", 64'(bus.mem_wr_en), 64'd1);
        chk("rt_addr", 64'(bus.mem_addr), 64'h200);
        chk("rt_bytes", 64'(bus.mem_usebytes), 64'hC);
        chk("rt_data", 64'(bus.mem_data), 64'h12340000);
        tick();
        chk("rt_wr_off", 64'(bus.mem_wr_en), 64'd0);

        // squash with retire and dispatch
        do_reset();
        dispatch(3);
        exec(3'd0, 32'h600, 4'b1111, 32'hCAFEF00D);
        bus.squash      = 1'b1;
        bus.retire_en   = 1'b1;
        bus.dispatch_en = 1'b1;
        tick();
        idle();
        chk("sq_wr", 64'(bus.mem_wr_en), 64'd1);
        chk("sq_addr", 64'(bus.mem_addr), 64'h600);
        chk("sq_data", 64'(bus.mem_data), 64'hCAFEF00D);
        chk("sq_tail", 64'(bus.sq_tail), 64'd1);
        look(32'h600, 3'd1);
        chk("sq_empty", 64'(bus.sq_result), 64'd0);
        dispatch(6);
        chk("sq_cnt6", 64'(bus.sq_full), 64'd0);
        dispatch(1);
        chk("sq_cnt7", 64'(bus.sq_full), 64'd1);
        chk("sq_tail0", 64'(bus.sq_tail), 64'd0);

        // reset mid-operation with retire pending
        exec(3'd1, 32'h700, 4'b1111, 32'h00000001);
        reset         = 1'b0;
        bus.retire_en = 1'b1;
        tick();
        bus.retire_en = 1'b0;
        look(32'h0, 3'd0);
        chk("rr_wr", 64'(bus.mem_wr_en), 64'd0);
        chk("rr_addr", 64'(bus.mem_addr), 64'd0);
        chk("rr_bytes", 64'(bus.mem_usebytes), 64'd0);
        chk("rr_data", 64'(bus.mem_data), 64'd0);
        chk("rr_tail", 64'(bus.sq_tail), 64'd0);
        chk("rr_full", 64'(bus.sq_full), 64'd0);
        chk("rr_res", 64'(bus.sq_result), 64'd0);
        reset = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
